cache_bus_arbiter: RTL

- Shares one next-level memory bus between the instruction cache and data cache miss/writeback paths.
- Each cache issues line-sized burst requests (read fill or write-back). The arbiter picks one owner, sequences LINE_WORDS beats on the memory bus, steers data back, then releases.
- Sits between the two cache instances and the memory model/controller in the testbench top.

---
 rtl/cache_bus_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cache_bus_arbiter
//
// Purpose:
//   Shares one next-level memory bus between the instruction-cache and the
//   data-cache miss/writeback paths. Each cache asks for one line-sized burst
//   (read fill or write-back). The arbiter picks an owner, runs LINE_WORDS
//   beats on the memory bus, steers read data and write-beat handshakes back
//   to the owner, pulses done for one cycle and then releases the bus.
//
// Ports:
//   clock, reset          system clock; synchronous active-high reset
//   i_req/i_we/i_addr     instruction-cache burst request, direction, base
//   i_wdata               instruction-cache current write beat
//   i_grant               instruction side owns the bus (XFER and DONE)
//   i_rvalid/i_rdata      read beat returned in the memory ack cycle
//   i_wnext               write beat consumed in the memory ack cycle
//   i_done                one-cycle completion pulse
//   d_*                   same set for the data cache
//   mem_req/mem_we        memory request (held for the burst) and direction
//   mem_addr/mem_wdata    current beat address and write data
//   mem_ack/mem_rdata     beat completion and read data from memory
//
// Configuration:
//   CACHE_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                             between the two caches; otherwise the data
//                             cache always wins.
// -----------------------------------------------------------------------------
module cache_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              i_grant,
    output logic              i_rvalid,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_wnext,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_wnext,
    output logic              d_done,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;

    // owner / last_served encoding: 0 = instruction cache, 1 = data cache
    logic              owner;
    logic              last_served;
    logic [BEAT_W-1:0] beat_cnt;

    logic              any_req;
    logic              sel_d;
    logic              beat_ack;
    logic              last_ack;
    logic              rd_beat;
    logic              wr_beat;

    assign any_req  = i_req | d_req;
    assign beat_ack = (state == XFER) && mem_ack;
    assign last_ack = beat_ack && (beat_cnt == LAST_BEAT);
    assign rd_beat  = beat_ack && !mem_we;
    assign wr_beat  = beat_ack && mem_we;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // On a tie, hand the bus to whichever side was not served last.
    assign sel_d = d_req && (!i_req || !last_served);
`else
    // Data misses stall the pipeline harder, so they always win a tie.
    logic unused_last_served;
    assign sel_d              = d_req;
    assign unused_last_served = last_served;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = XFER;
                end
            end
            XFER: begin
                if (last_ack) begin
                    state_n = DONE;
                end
            end
            // Requests are deliberately not looked at here, which guarantees
            // an idle cycle between bursts for the requester to drop req.
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst bookkeeping: owner latch, beat counter, memory-side registers,
    // registered grant and done pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= 1'b0;
            last_served <= 1'b0;
            beat_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            i_grant     <= 1'b0;
            d_grant     <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= sel_d;
                        last_served <= sel_d;
                        mem_we      <= sel_d ? d_we : i_we;
                        mem_addr    <= sel_d ? d_addr : i_addr;
                        beat_cnt    <= '0;
                        mem_req     <= 1'b1;
                        i_grant     <= !sel_d;
                        d_grant     <= sel_d;
                    end
                end
                XFER: begin
                    // Without an ack the beat stalls and everything holds.
                    // The owner's req is not consulted: a started burst
                    // always runs to completion.
                    if (beat_ack) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (last_ack) begin
                            mem_req <= 1'b0;
                            i_done  <= !owner;
                            d_done  <= owner;
                        end
                    end
                end
                DONE: begin
                    i_grant <= 1'b0;
                    d_grant <= 1'b0;
                    i_done  <= 1'b0;
                    d_done  <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                    i_grant <= 1'b0;
                    d_grant <= 1'b0;
                    i_done  <= 1'b0;
                    d_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Combinational steering back to the owner. Grants are only ever set
    // for the owner, so gating with the grant keeps the other side quiet.
    // ------------------------------------------------------------------
    assign i_rvalid = rd_beat && i_grant;
    assign d_rvalid = rd_beat && d_grant;
    assign i_wnext  = wr_beat && i_grant;
    assign d_wnext  = wr_beat && d_grant;

    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    // Write data follows the owner's current beat for the whole grant, so
    // the memory sees it already valid in the cycle it chooses to ack.
    always_comb begin
        mem_wdata = '0;
        if (mem_we) begin
            if (d_grant) begin
                mem_wdata = d_wdata;
            end else if (i_grant) begin
                mem_wdata = i_wdata;
            end
        end
    end

endmodule
